// File: rtl/multi_sum_pkg.sv
// Shared definitions for the accumulate-N-samples engine:
// the 1-bit state encoding and the sample-count clamp.
package multi_sum_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  // n=0 still takes one sample; requests beyond the depth are capped.
  function automatic int clamp_n(input int n, input int max_n);
    if (n == 0)     return 1;
    if (n > max_n)  return max_n;
    return n;
  endfunction

endpackage

// File: rtl/multi_sum_if.sv
// Sample/result bus between a streaming source, the summing engine and a
// polling consumer. The engine takes the slave side.
interface multi_sum_if #(
  parameter int DW    = 16,
  parameter int MAX_N = 8,
  parameter int CW    = $clog2(MAX_N + 1),
  parameter int SW    = DW + $clog2(MAX_N)
);
  logic [DW-1:0] din;
  logic          irdy;
  logic [CW-1:0] n;
  logic [SW-1:0] dout;
  logic          ordy;
  logic          busy;
  logic          ovf;

  modport master (output din, irdy, n, input dout, ordy, busy, ovf);
  modport slave  (input din, irdy, n, output dout, ordy, busy, ovf);
endinterface

// File: rtl/sample_down_counter.sv
// Loadable down counter tracking the samples still to be added;
// `last` marks the edge that takes the final sample.
module sample_down_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] count,
  output logic          last
);
  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec && cnt_q != '0)
      cnt_d = cnt_q - CW'(1);
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count = cnt_q;
  assign last  = (cnt_q == CW'(1));
endmodule

// File: rtl/multi_sum_datapath.sv
// Accumulates 1..MAX_N consecutive samples per start request and holds the sum.
// Define MULTI_SUM_SATURATE_EN to clamp overflowing sums to all ones instead of wrapping.
module multi_sum_datapath
  import multi_sum_pkg::*;
#(
  parameter int DW    = 16,
  parameter int MAX_N = 8,
  parameter int CW    = $clog2(MAX_N + 1),
  parameter int SW    = DW + $clog2(MAX_N)
) (
  input  logic      clk,
  input  logic      reset,
  multi_sum_if.slave bus
);
  // One spare bit above the wider of sample and sum so a carry is always visible.
  localparam int AW = ((DW > SW) ? DW : SW) + 1;

  state_e        state_q, state_d;
  logic [SW-1:0] dout_q, dout_d;
  logic          ordy_q, ordy_d;
  logic          ovf_q, ovf_d;

  logic [CW-1:0] n_eff;
  logic          start;
  logic [AW-1:0] din_w, sum_w;
  logic          carry;
  logic [SW-1:0] next_sum;
  logic          cnt_load, cnt_dec, cnt_last;
  logic [CW-1:0] cnt_count;

  assign n_eff = CW'(clamp_n(int'(bus.n), MAX_N));
  assign start = (state_q == ST_IDLE) && bus.irdy;
  assign din_w = AW'(bus.din);
  assign sum_w = start ? din_w : (AW'(dout_q) + din_w);
  assign carry = |sum_w[AW-1:SW];

`ifdef MULTI_SUM_SATURATE_EN
  // Once pinned at all ones, any further non-zero sample carries again, so it stays pinned.
  assign next_sum = carry ? '1 : sum_w[SW-1:0];
`else
  assign next_sum = sum_w[SW-1:0];
`endif

  always_comb begin
    state_d  = state_q;
    dout_d   = dout_q;
    ordy_d   = ordy_q;
    ovf_d    = ovf_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.irdy) begin
          dout_d = next_sum;
          ovf_d  = carry;
          if (n_eff == CW'(1)) begin
            ordy_d = 1'b1;
          end else begin
            ordy_d   = 1'b0;
            cnt_load = 1'b1;
            state_d  = ST_ACCUM;
          end
        end
      end
      ST_ACCUM: begin
        dout_d  = next_sum;
        ovf_d   = ovf_q | carry;
        cnt_dec = 1'b1;
        if (cnt_last) begin
          ordy_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dout_q  <= '0;
      ordy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      ordy_q  <= ordy_d;
      ovf_q   <= ovf_d;
    end
  end

  sample_down_counter #(.CW(CW)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (n_eff - CW'(1)),
    .count    (cnt_count),
    .last     (cnt_last)
  );

  assign bus.dout = dout_q;
  assign bus.ordy = ordy_q;
  assign bus.busy = (state_q == ST_ACCUM);
  assign bus.ovf  = ovf_q;

  // The remaining-sample count is only consumed through `last`.
  logic unused_cnt;
  assign unused_cnt = ^cnt_count;
endmodule

// File: tb/tb_multi_sum_datapath.sv
// Bench for multi_sum_datapath: a default-width instance plus a narrow (SW=16)
// instance so overflow is reachable; results compared against a plain-arithmetic model.
module tb_multi_sum_datapath;
  localparam int DW    = 16;
  localparam int MAX_N = 8;
  localparam int CW    = 4;
  localparam int SW_W  = 19;
  localparam int SW_N  = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multi_sum_if #(.DW(DW), .MAX_N(MAX_N))             w_if ();
  multi_sum_if #(.DW(DW), .MAX_N(MAX_N), .SW(SW_N)) n_if ();

  multi_sum_datapath #(.DW(DW), .MAX_N(MAX_N)) u_wide (
    .clk (clk), .reset (reset), .bus (w_if.slave)
  );
  multi_sum_datapath #(.DW(DW), .MAX_N(MAX_N), .SW(SW_N)) u_narrow (
    .clk (clk), .reset (reset), .bus (n_if.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] smp [16];

  task automatic drive(input int sel, input logic irdy, input int nv, input logic [DW-1:0] d);
    if (sel == 0) begin
      w_if.irdy = irdy; w_if.n = CW'(nv); w_if.din = d;
    end else begin
      n_if.irdy = irdy; n_if.n = CW'(nv); n_if.din = d;
    end
  endtask

  function automatic logic [SW_W-1:0] obs_dout(input int sel);
    return (sel == 0) ? w_if.dout : SW_W'(n_if.dout);
  endfunction
  function automatic logic obs_ordy(input int sel);
    return (sel == 0) ? w_if.ordy : n_if.ordy;
  endfunction
  function automatic logic obs_busy(input int sel);
    return (sel == 0) ? w_if.busy : n_if.busy;
  endfunction
  function automatic logic obs_ovf(input int sel);
    return (sel == 0) ? w_if.ovf : n_if.ovf;
  endfunction

  // Reference: true sum of the first n_eff samples, then wrap or saturate at 2^sw-1.
  function automatic void model(input int nv, input int sw, output logic [SW_W-1:0] e_dout,
                                output logic e_ovf, output int e_lat);
    int neff;
    longint unsigned total;
    longint unsigned lim;
    neff  = (nv == 0) ? 1 : ((nv > MAX_N) ? MAX_N : nv);
    total = 0;
    lim   = (64'd1 << sw) - 1;
    for (int k = 0; k < neff; k++) total += longint'(smp[k]);
    e_ovf = (total > lim);
`ifdef MULTI_SUM_SATURATE_EN
    e_dout = e_ovf ? SW_W'(lim) : SW_W'(total);
`else
    e_dout = SW_W'(total & lim);
`endif
    e_lat = neff;
  endfunction

  // Starts one sum on the selected instance and checks busy/ordy timing and the result.
  task automatic run_sum(input int sel, input int nv, input string tag);
    logic [SW_W-1:0] e_dout;
    logic e_ovf;
    int lat;
    int busy_cnt;
    busy_cnt = 0;
    model(nv, (sel == 0) ? SW_W : SW_N, e_dout, e_ovf, lat);
    @(negedge clk);
    drive(sel, 1'b1, nv, smp[0]);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      drive(sel, 1'b0, nv, (k < lat) ? smp[k] : DW'($urandom));
      if (obs_busy(sel) === 1'b1) busy_cnt++;
      if (k < lat) begin
        n_checks++;
        if (obs_ordy(sel) !== 1'b0) begin
          n_fail++;
          $display("FAIL %s ordy_early edge %0d: got %b want 0", tag, k, obs_ordy(sel));
        end
      end
    end
    n_checks++;
    if (obs_ordy(sel) !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ordy: got %b want 1", tag, obs_ordy(sel));
    end
    n_checks++;
    if (obs_dout(sel) !== e_dout) begin
      n_fail++;
      $display("FAIL %s dout: got %h want %h", tag, obs_dout(sel), e_dout);
    end
    n_checks++;
    if (obs_ovf(sel) !== e_ovf) begin
      n_fail++;
      $display("FAIL %s ovf: got %b want %b", tag, obs_ovf(sel), e_ovf);
    end
    n_checks++;
    if (busy_cnt != lat - 1) begin
      n_fail++;
      $display("FAIL %s busy_cycles: got %0d want %0d", tag, busy_cnt, lat - 1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 1'b0, 0, '0);
    drive(1, 1'b0, 0, '0);
    #2;
    n_checks++;
    if ({w_if.dout, w_if.ordy, w_if.busy, w_if.ovf} !== '0) begin
      n_fail++;
      $display("FAIL reset_wide: got %h/%b/%b/%b want all 0", w_if.dout, w_if.ordy, w_if.busy, w_if.ovf);
    end
    n_checks++;
    if ({n_if.dout, n_if.ordy, n_if.busy, n_if.ovf} !== '0) begin
      n_fail++;
      $display("FAIL reset_narrow: got %h/%b/%b/%b want all 0", n_if.dout, n_if.ordy, n_if.busy, n_if.ovf);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    smp[0] = 16'd5; smp[1] = 16'd7; smp[2] = 16'd9;
    run_sum(0, 3, "basic_n3");
    smp[0] = 16'hFFFF;
    run_sum(0, 1, "single_ffff");
  endtask

  task automatic test_clamp();
    smp[0] = 16'd4;
    run_sum(0, 0, "clamp_n0");
    for (int k = 0; k < 16; k++) smp[k] = 16'd1;
    run_sum(0, 15, "clamp_n15");
  endtask

  task automatic test_hold();
    logic [SW_W-1:0] held;
    for (int k = 0; k < 4; k++) smp[k] = DW'($urandom);
    run_sum(0, 4, "hold_setup");
    held = SW_W'(smp[0]) + SW_W'(smp[1]) + SW_W'(smp[2]) + SW_W'(smp[3]);
    repeat (3) begin
      @(negedge clk);
      drive(0, 1'b0, $urandom_range(0, 15), DW'($urandom));
    end
    n_checks++;
    if (w_if.dout !== held || w_if.ordy !== 1'b1 || w_if.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: got %h/%b/%b want %h/1/0", w_if.dout, w_if.ordy, w_if.busy, held);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); drive(0, 1'b1, 2, 16'd1);
    @(negedge clk); drive(0, 1'b1, 2, 16'd2);
    @(negedge clk);
    n_checks++;
    if (w_if.dout !== 19'd3 || w_if.ordy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: got %h/%b want 3/1", w_if.dout, w_if.ordy);
    end
    drive(0, 1'b1, 2, 16'd3);
    @(negedge clk);
    n_checks++;
    if (w_if.ordy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_ordy_pulse: got %b want 0", w_if.ordy);
    end
    drive(0, 1'b1, 2, 16'd4);
    @(negedge clk);
    drive(0, 1'b0, 2, 16'd0);
    n_checks++;
    if (w_if.dout !== 19'd7 || w_if.ordy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second: got %h/%b want 7/1", w_if.dout, w_if.ordy);
    end
  endtask

  task automatic test_overflow();
    smp[0] = 16'hFFFF; smp[1] = 16'h0002;
    run_sum(1, 2, "ovf_narrow");
    run_sum(0, 2, "ovf_wide_none");
    smp[0] = 16'd3; smp[1] = 16'd4;
    run_sum(1, 2, "ovf_cleared");
  endtask

  task automatic test_reset_mid();
    @(negedge clk); drive(0, 1'b1, 4, 16'd100);
    @(negedge clk); drive(0, 1'b0, 4, 16'd200);
    @(negedge clk); drive(0, 1'b0, 4, 16'd300);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({w_if.dout, w_if.ordy, w_if.busy, w_if.ovf} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %h/%b/%b/%b want all 0", w_if.dout, w_if.ordy, w_if.busy, w_if.ovf);
    end
    #1;
    reset = 1'b0;
    drive(0, 1'b0, 0, '0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (w_if.ordy !== 1'b0 || w_if.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_no_result: got ordy=%b busy=%b want 0/0", w_if.ordy, w_if.busy);
    end
    smp[0] = 16'd10; smp[1] = 16'd20;
    run_sum(0, 2, "after_reset");
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      int sel;
      sel = it % 2;
      for (int k = 0; k < 16; k++)
        smp[k] = (it % 3 == 0) ? DW'($urandom_range(16'hF000, 16'hFFFF)) : DW'($urandom);
      run_sum(sel, $urandom_range(0, 15), (sel == 0) ? "rand_wide" : "rand_narrow");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_hold();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_sum_datapath.md
Name: multi_sum_datapath

Overview:
- Parametrised accumulate-N-samples engine: on `irdy`, sums `din` over a run-time-selected number of consecutive cycles (1..MAX_N).
- Presents the sum on `dout` and raises `ordy`.
- Generalises the fixed three-sample adder datapath/FSM pair with width, depth, busy/overflow status and optional saturation.
- Sits between a streaming sample source and a consumer that polls `ordy`.

Parameters:
- DW, 16, input sample width (bits, unsigned).
- MAX_N, 8, maximum samples per sum (>=2).
- CW, $clog2(MAX_N+1), width of the sample-count input.
- SW, DW+$clog2(MAX_N), accumulator/output width; may be set < default, which makes overflow possible.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- din  in  DW  sample; first sample valid in the `irdy` cycle, then one per cycle.
- irdy  in  1  start request, honoured only in IDLE.
- n  in  CW  samples to sum; sampled only on the start edge.
- dout  out  SW  accumulated sum (registered).
- ordy  out  1  result valid; held until the next start.
- busy  out  1  high while in ACCUM.
- ovf  out  1  sum exceeded 2^SW-1 during the current operation (sticky until the next start).

Behaviour:
- Reset is asynchronous and active-high. It drives `dout`=0, `ordy`=0, `busy`=0, `ovf`=0, the counter to 0 and the state to IDLE.
- Reset mid-operation aborts the sum. No partial result is flagged.
- n_eff clamping: n=0 gives 1; n>MAX_N gives MAX_N; otherwise n_eff=n.
- IDLE, irdy=0: hold all registers.
- IDLE, irdy=1 (start edge):
  - dout <= zero-extended din; ovf <= 0 (or 1 if DW>SW and din doesn't fit).
  - If n_eff=1: ordy <= 1 and stay IDLE; set overrides clear in this case.
  - Otherwise: ordy <= 0, busy <= 1, cnt <= n_eff-1, go to ACCUM.
- ACCUM:
  - Each edge: dout <= dout+din computed SW+1 wide; cnt <= cnt-1; irdy ignored.
  - Overflow: if carry out, ovf <= 1 and dout <= low SW bits (wrap).
  - On the edge where cnt=1: ordy <= 1, busy <= 0, go to IDLE.
- Latency: n_eff samples taken on n_eff consecutive edges, start edge included. ordy is high after the n_eff-th edge.
- Back-to-back: irdy may be asserted the cycle ordy rises. ordy then stays high for exactly one cycle and clears on the new start edge. Sustained throughput is one result per n_eff cycles.
- States: IDLE, ACCUM; 1-bit state register.
- Arithmetic is unsigned and never sign-extended. dout is stable whenever ordy=1.

Optional Feature:
- Macro MULTI_SUM_SATURATE_EN.
- Defined: on any carry out, dout <= all ones (2^SW-1) and stays there for the rest of the operation; ovf <= 1.
- Undefined: modulo-2^SW wrap; ovf is still set.
- No effect when SW is at its default, since overflow is then impossible.

Decomposition:
- Package multi_sum_pkg:
  - State encoding constants (ST_IDLE=1'b0, ST_ACCUM=1'b1).
  - Clamp function for n_eff.
- One sub-module: sample_down_counter.
  - Loadable CW-bit down counter with load and decrement enables.
  - Asserts `last` when the count equals 1.
- The FSM and accumulator stay in the top module.

Test Plan:
- Defaults, n=3, din=5,7,9 on consecutive cycles from the irdy cycle -> ordy=1 after the 3rd edge, dout=21, busy high 2 cycles, ovf=0.
- n=1, din=16'hFFFF -> after 1 edge dout=19'h0FFFF, ordy=1, busy never high.
- Clamping: n=0, din=4 -> single-sample sum dout=4; n=15 with MAX_N=8 and din=1 -> dout=8 after 8 edges.
- Back-to-back: irdy held high, n=2, din=1,2,3,4 -> dout=3 with ordy high exactly 1 cycle, then dout=7 with ordy=1.
- Overflow with SW=16, n=2, din=16'hFFFF then 16'h0002:
  - without the macro -> dout=16'h0001, ovf=1;
  - with MULTI_SUM_SATURATE_EN -> dout=16'hFFFF, ovf=1.
- Reset pulse in the 2nd ACCUM cycle of an n=4 sum -> all outputs 0 asynchronously; a fresh n=2 sum of 10,20 then yields dout=30.
